// File: rtl/hist_update_ctrl_if.sv
// Signal bundle between the histogram update controller, its sample
// source, the host readout path and the 32-bit register bank.
// Optional macro HIST_WEIGHT_EN adds the per-sample weight input.
interface hist_update_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
`ifdef HIST_WEIGHT_EN
  , parameter int WEIGHT_W = 8
`endif
);

  logic              run_en;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_bin;
`ifdef HIST_WEIGHT_EN
  logic [WEIGHT_W-1:0] in_weight;
`endif
  logic              host_rd_req;
  logic [ADDR_W-1:0] host_rd_addr;
  logic              host_rd_valid;
  logic [DATA_W-1:0] host_rd_data;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] bank_raddr;
  logic [DATA_W-1:0] bank_rdata;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] total_count;
  logic              sat_flag;

  // Environment side: sample source, host, clear command and the bank.
  modport master (
    output run_en, in_valid, in_bin,
`ifdef HIST_WEIGHT_EN
    output in_weight,
`endif
    output host_rd_req, host_rd_addr, clr_start, bank_rdata,
    input  in_ready, host_rd_valid, host_rd_data, clr_busy, clr_done,
    input  bank_raddr, bank_we, bank_waddr, bank_wdata, total_count, sat_flag
  );

  // Controller side.
  modport slave (
    input  run_en, in_valid, in_bin,
`ifdef HIST_WEIGHT_EN
    input  in_weight,
`endif
    input  host_rd_req, host_rd_addr, clr_start, bank_rdata,
    output in_ready, host_rd_valid, host_rd_data, clr_busy, clr_done,
    output bank_raddr, bank_we, bank_waddr, bank_wdata, total_count, sat_flag
  );

endinterface

// File: rtl/hist_update_ctrl.sv
// Histogram update controller: read-modify-write increment of bank bins
// from a sample stream, host readout sharing the single read port, and a
// full-bank clear sweep. Optional macro HIST_WEIGHT_EN replaces the fixed
// increment of 1 with a per-sample weight.
module hist_update_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
`ifdef HIST_WEIGHT_EN
  , parameter int WEIGHT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              clr,
  hist_update_ctrl_if.slave bus
);

  localparam int NUM_BINS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {IDLE, RUN, CLR_WAIT, CLR_SWEEP} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_s1Valid;
  logic [ADDR_W-1:0] r_s1Bin;
`ifdef HIST_WEIGHT_EN
  logic [WEIGHT_W-1:0] r_s1Weight;
`endif
  logic [ADDR_W-1:0] r_sweepAddr;
  logic              r_hostRdValid;
  logic [DATA_W-1:0] r_hostRdData;
  logic              r_clrDone;
  logic [DATA_W-1:0] r_totalCount;
  logic              r_satFlag;

  logic              w_clrActive;
  logic              w_inReady;
  logic              w_handshake;
  logic              w_hostGrant;
  logic              w_sweepEntry;
  logic              w_sweepLast;
  logic [DATA_W-1:0] w_s1Inc;
  logic [DATA_W-1:0] w_sampleInc;
  logic [DATA_W:0]   w_binSum;
  logic [DATA_W:0]   w_totalSum;
  logic              w_binOvf;
  logic [DATA_W-1:0] w_binNext;
  logic [DATA_W-1:0] w_totalNext;

`ifdef HIST_WEIGHT_EN
  assign w_s1Inc     = DATA_W'(r_s1Weight);
  assign w_sampleInc = DATA_W'(bus.in_weight);
`else
  assign w_s1Inc     = DATA_W'(1);
  assign w_sampleInc = DATA_W'(1);
`endif

  assign w_clrActive  = (r_state == CLR_WAIT) || (r_state == CLR_SWEEP);
  assign w_inReady    = (r_state == RUN) && !bus.host_rd_req && !bus.clr_start;
  assign w_handshake  = bus.in_valid && w_inReady;
  assign w_hostGrant  = bus.host_rd_req && !r_s1Valid && !r_hostRdValid && !w_clrActive;
  assign w_sweepEntry = (r_state == CLR_WAIT) && !r_s1Valid;
  assign w_sweepLast  = (r_state == CLR_SWEEP) && (r_sweepAddr == LAST_ADDR);

  // Saturating adders: an extra carry bit flags overflow past all-ones.
  assign w_binSum    = {1'b0, bus.bank_rdata} + {1'b0, w_s1Inc};
  assign w_binOvf    = w_binSum[DATA_W];
  assign w_binNext   = w_binOvf ? '1 : w_binSum[DATA_W-1:0];
  assign w_totalSum  = {1'b0, r_totalCount} + {1'b0, w_sampleInc};
  assign w_totalNext = w_totalSum[DATA_W] ? '1 : w_totalSum[DATA_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next state: a clear command outranks run/idle changes; the sweep waits for S1 to drain.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.clr_start)   w_nextState = CLR_WAIT;
        else if (bus.run_en) w_nextState = RUN;
      end
      RUN: begin
        if (bus.clr_start)    w_nextState = CLR_WAIT;
        else if (!bus.run_en) w_nextState = IDLE;
      end
      CLR_WAIT: begin
        if (!r_s1Valid) w_nextState = CLR_SWEEP;
      end
      CLR_SWEEP: begin
        if (w_sweepLast) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Bank port steering: sweep writes zeros, S1 does read-modify-write, otherwise host may read.
  always_comb begin
    bus.bank_raddr = '0;
    bus.bank_we    = 1'b0;
    bus.bank_waddr = '0;
    bus.bank_wdata = '0;
    if (r_state == CLR_SWEEP) begin
      bus.bank_we    = 1'b1;
      bus.bank_waddr = r_sweepAddr;
    end else if (r_s1Valid) begin
      bus.bank_raddr = r_s1Bin;
      bus.bank_we    = 1'b1;
      bus.bank_waddr = r_s1Bin;
      bus.bank_wdata = w_binNext;
    end else if (w_hostGrant) begin
      bus.bank_raddr = bus.host_rd_addr;
    end
  end

  // Stage S1 captures each accepted sample for its update one cycle later.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_s1Valid <= 1'b0;
      r_s1Bin   <= '0;
`ifdef HIST_WEIGHT_EN
      r_s1Weight <= '0;
`endif
    end else begin
      r_s1Valid <= w_handshake;
      if (w_handshake) begin
        r_s1Bin <= bus.in_bin;
`ifdef HIST_WEIGHT_EN
        r_s1Weight <= bus.in_weight;
`endif
      end
    end
  end

  // Sweep address restarts at zero on entry and walks one bin per cycle.
  always_ff @(posedge clk) begin
    if (clr)                       r_sweepAddr <= '0;
    else if (w_sweepEntry)         r_sweepAddr <= '0;
    else if (r_state == CLR_SWEEP) r_sweepAddr <= r_sweepAddr + 1'b1;
  end

  // Host readout: data registered from the bank in the grant cycle, valid for one cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_hostRdValid <= 1'b0;
      r_hostRdData  <= '0;
    end else begin
      r_hostRdValid <= w_hostGrant;
      if (w_hostGrant) r_hostRdData <= bus.bank_rdata;
    end
  end

  // Done pulse follows the write to the last bin.
  always_ff @(posedge clk) begin
    if (clr) r_clrDone <= 1'b0;
    else     r_clrDone <= w_sweepLast;
  end

  // Sample total and sticky saturation flag; both restart when a sweep begins.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_totalCount <= '0;
      r_satFlag    <= 1'b0;
    end else if (w_sweepEntry) begin
      r_totalCount <= '0;
      r_satFlag    <= 1'b0;
    end else begin
      if (w_handshake) r_totalCount <= w_totalNext;
      if (r_s1Valid && (r_state != CLR_SWEEP) && w_binOvf) r_satFlag <= 1'b1;
    end
  end

  assign bus.in_ready      = w_inReady;
  assign bus.host_rd_valid = r_hostRdValid;
  assign bus.host_rd_data  = r_hostRdData;
  assign bus.clr_busy      = w_clrActive;
  assign bus.clr_done      = r_clrDone;
  assign bus.total_count   = r_totalCount;
  assign bus.sat_flag      = r_satFlag;

endmodule

// File: tb/tb_hist_update_ctrl.sv
// Self-checking bench for hist_update_ctrl: a register-array bank, random
// sample streams and a reference model of bin counts, total and saturation.
// Build with HIST_WEIGHT_EN defined to exercise weighted increments.
module tb_hist_update_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int NBINS = 16;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic clr;

`ifdef HIST_WEIGHT_EN
  hist_update_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEIGHT_W(8)) bus ();
  hist_update_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEIGHT_W(8)) dut (
    .clk(clk), .clr(clr), .bus(bus));
`else
  hist_update_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  hist_update_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .clr(clr), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Bank: combinational read, synchronous write; bench pokes only when the DUT is not writing.
  logic [DATA_W-1:0] bank [NBINS];
  logic              pokeEn = 1'b0;
  logic [ADDR_W-1:0] pokeAddr = '0;
  logic [DATA_W-1:0] pokeData = '0;

  assign bus.bank_rdata = bank[bus.bank_raddr];

  always @(posedge clk) begin
    if (bus.bank_we)  bank[bus.bank_waddr] <= bus.bank_wdata;
    else if (pokeEn)  bank[pokeAddr] <= pokeData;
  end

  // Reference model.
  longint unsigned expBins [NBINS];
  longint unsigned expTotal;
  logic            expSat;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelSample(input int bin, input longint unsigned inc);
    longint unsigned s;
    s = expBins[bin] + inc;
    if (s > MAXV) begin
      expBins[bin] = MAXV;
      expSat = 1'b1;
    end else begin
      expBins[bin] = s;
    end
    expTotal = (expTotal + inc > MAXV) ? MAXV : expTotal + inc;
  endtask

  task automatic poke(input int addr, input longint unsigned data);
    pokeEn   = 1'b1;
    pokeAddr = ADDR_W'(addr);
    pokeData = DATA_W'(data);
    tick();
    pokeEn = 1'b0;
    expBins[addr] = data;
  endtask

  // One sample cycle: check readiness, update model on acceptance, check the write one cycle later.
  task automatic applyStimulus(input logic valid, input int bin, input int weight, input logic expReady);
    longint unsigned inc;
    logic hs;
    bus.in_valid = valid;
    bus.in_bin   = ADDR_W'(bin);
`ifdef HIST_WEIGHT_EN
    bus.in_weight = 8'(weight);
    inc = longint'(weight);
`else
    inc = 1;
    if (weight < 0) inc = 1;
`endif
    #1;
    checkOutput("in_ready", bus.in_ready, expReady);
    hs = valid && expReady;
    if (hs) modelSample(bin, inc);
    tick();
    checkOutput("s1_we", bus.bank_we, hs);
    if (hs) checkOutput("s1_waddr", bus.bank_waddr, bin);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic compareBins(input string tag);
    for (int i = 0; i < NBINS; i++) checkOutput(tag, bank[i], expBins[i]);
    checkOutput("total_count", bus.total_count, expTotal);
    checkOutput("sat_flag", bus.sat_flag, expSat);
  endtask

  // Host read with bounded wait; optionally keeps offering samples that must be refused.
  task automatic hostRead(input int addr, input logic streaming);
    logic found;
    longint unsigned expData;
    found = 1'b0;
    bus.host_rd_req  = 1'b1;
    bus.host_rd_addr = ADDR_W'(addr);
    bus.in_valid     = streaming;
    bus.in_bin       = ADDR_W'($urandom_range(0, NBINS - 1));
    #1;
    checkOutput("rdy_hostreq", bus.in_ready, 1'b0);
    expData = expBins[addr];
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.host_rd_valid) begin
        found = 1'b1;
        checkOutput("host_rd_data", bus.host_rd_data, expData);
        bus.host_rd_req = 1'b0;
        break;
      end
    end
    checkOutput("host_rd_latency", found, 1'b1);
    bus.host_rd_req = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    checkOutput("host_rd_pulse", bus.host_rd_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic sawDone;
    logic found;
    int nextAddr;

    clr = 1'b1;
    bus.run_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bin = '0;
`ifdef HIST_WEIGHT_EN
    bus.in_weight = '0;
`endif
    bus.host_rd_req = 1'b0;
    bus.host_rd_addr = '0;
    bus.clr_start = 1'b0;
    expTotal = 0;
    expSat = 1'b0;
    tick();
    for (int i = 0; i < NBINS; i++) poke(i, 0);

    $display("[TB] reset values");
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_bank_we", bus.bank_we, 1'b0);
    checkOutput("rst_raddr", bus.bank_raddr, 0);
    checkOutput("rst_waddr", bus.bank_waddr, 0);
    checkOutput("rst_wdata", bus.bank_wdata, 0);
    checkOutput("rst_rd_valid", bus.host_rd_valid, 1'b0);
    checkOutput("rst_rd_data", bus.host_rd_data, 0);
    checkOutput("rst_clr_busy", bus.clr_busy, 1'b0);
    checkOutput("rst_clr_done", bus.clr_done, 1'b0);
    checkOutput("rst_total", bus.total_count, 0);
    checkOutput("rst_sat", bus.sat_flag, 1'b0);

    clr = 1'b0;
    bus.run_en = 1'b1;
    tick();

    $display("[TB] back-to-back bins 3,3,3,5");
    applyStimulus(1'b1, 3, 1, 1'b1);
    applyStimulus(1'b1, 3, 1, 1'b1);
    applyStimulus(1'b1, 3, 1, 1'b1);
    applyStimulus(1'b1, 5, 1, 1'b1);
    drain();
    checkOutput("bin3_const", bank[3], 3);
    checkOutput("bin5_const", bank[5], 1);
    checkOutput("total4_const", bus.total_count, 4);
    compareBins("b2b_bins");

    $display("[TB] saturation on bin 7");
    poke(7, 64'hFFFF_FFFE);
    applyStimulus(1'b1, 7, 1, 1'b1);
    drain();
    checkOutput("sat_after_first", bus.sat_flag, 1'b0);
    checkOutput("bin7_first", bank[7], 32'hFFFF_FFFF);
    applyStimulus(1'b1, 7, 1, 1'b1);
    drain();
    checkOutput("sat_after_second", bus.sat_flag, 1'b1);
    checkOutput("bin7_second", bank[7], 32'hFFFF_FFFF);

    $display("[TB] random stream");
    for (int n = 0; n < 150; n++)
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, NBINS - 1)),
                    int'($urandom_range(0, 255)), 1'b1);
    drain();
    compareBins("rand_bins");
    checkOutput("sat_sticky", bus.sat_flag, 1'b1);

    $display("[TB] host read during streaming");
    for (int n = 0; n < 5; n++)
      applyStimulus(1'b1, int'($urandom_range(0, NBINS - 1)), int'($urandom_range(0, 255)), 1'b1);
    hostRead(3, 1'b1);
    bus.run_en = 1'b0;
    tick();
    for (int n = 0; n < 3; n++) hostRead(int'($urandom_range(0, NBINS - 1)), 1'b0);
    bus.run_en = 1'b1;
    tick();

    $display("[TB] clear sweep mid-stream");
    for (int n = 0; n < 4; n++)
      applyStimulus(1'b1, int'($urandom_range(0, NBINS - 1)), int'($urandom_range(0, 255)), 1'b1);
    bus.clr_start = 1'b1;
    bus.run_en = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    checkOutput("rdy_clrstart", bus.in_ready, 1'b0);
    tick();
    bus.clr_start = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("clr_busy_set", bus.clr_busy, 1'b1);
    nextAddr = 0;
    sawDone = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.clr_start = 1'b0;
      if (bus.clr_done) begin
        sawDone = 1'b1;
        break;
      end
      if (bus.bank_we) begin
        checkOutput("sweep_addr", bus.bank_waddr, nextAddr);
        checkOutput("sweep_data", bus.bank_wdata, 0);
        checkOutput("sweep_busy", bus.clr_busy, 1'b1);
        if (nextAddr == 0) begin
          checkOutput("sweep_total", bus.total_count, 0);
          checkOutput("sweep_sat", bus.sat_flag, 1'b0);
        end
        if (nextAddr == 3) bus.clr_start = 1'b1;
        nextAddr++;
      end
      tick();
    end
    bus.clr_start = 1'b0;
    checkOutput("clr_done_seen", sawDone, 1'b1);
    checkOutput("sweep_count", nextAddr, NBINS);
    checkOutput("clr_busy_end", bus.clr_busy, 1'b0);
    checkOutput("idle_ready", bus.in_ready, 1'b0);
    tick();
    checkOutput("clr_done_pulse", bus.clr_done, 1'b0);
    for (int i = 0; i < NBINS; i++) expBins[i] = 0;
    expTotal = 0;
    expSat = 1'b0;
    compareBins("clr_bins");

    $display("[TB] abort sweep with clr");
    for (int i = 0; i < NBINS; i++) poke(i, longint'($urandom));
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.bank_we && (bus.bank_waddr == 4'd6)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("abort_reach6", found, 1'b1);
    clr = 1'b1;
    tick();
    checkOutput("abort_we", bus.bank_we, 1'b0);
    checkOutput("abort_busy", bus.clr_busy, 1'b0);
    checkOutput("abort_done", bus.clr_done, 1'b0);
    clr = 1'b0;
    for (int i = 0; i <= 6; i++) expBins[i] = 0;
    expTotal = 0;
    expSat = 1'b0;
    compareBins("abort_bins");
    checkOutput("abort_idle_ready", bus.in_ready, 1'b0);
    bus.run_en = 1'b1;
    tick();
    checkOutput("abort_run_ready", bus.in_ready, 1'b1);

`ifdef HIST_WEIGHT_EN
    $display("[TB] weighted bin 2");
    poke(2, 0);
    applyStimulus(1'b1, 2, 10, 1'b1);
    applyStimulus(1'b1, 2, 0, 1'b1);
    applyStimulus(1'b1, 2, 250, 1'b1);
    drain();
    checkOutput("w_bin2_const", bank[2], 260);
    checkOutput("w_total_const", bus.total_count, 260);
    compareBins("weight_bins");
`else
    $display("[TB] unit increments bin 2");
    poke(2, 0);
    applyStimulus(1'b1, 2, 10, 1'b1);
    applyStimulus(1'b1, 2, 0, 1'b1);
    applyStimulus(1'b1, 2, 250, 1'b1);
    drain();
    checkOutput("u_bin2_const", bank[2], 3);
    checkOutput("u_total_const", bus.total_count, 3);
    compareBins("unit_bins");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
